// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: channel FSM encoding and counter sizing.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StDbPress   = 2'd1,
        StHeld      = 2'd2,
        StDbRelease = 2'd3
    } key_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM, auto-repeat timer and registered strobes.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 1000000,
    parameter int unsigned REPEAT_DLY_CYC = 50000000,
    parameter int unsigned REPEAT_PER_CYC = 10000000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    localparam int unsigned CntW  = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned RcntW = cnt_width(max_u(REPEAT_DLY_CYC, REPEAT_PER_CYC));

    localparam logic [CntW-1:0]  DbLast  = CntW'(DEBOUNCE_CYC - 1);
    localparam logic [CntW-1:0]  CntMax  = '1;
    localparam logic [RcntW-1:0] DlyLast = RcntW'(REPEAT_DLY_CYC - 1);
    localparam logic [RcntW-1:0] PerLast = RcntW'(REPEAT_PER_CYC - 1);
    localparam logic [RcntW-1:0] RcntMax = '1;

    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             rep_q, rep_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_q, rpt_d;
    logic [RcntW-1:0] rpt_last;

    assign s        = sync_q[1] ^ KEY_ACTIVE_LOW;
    // The first pulse waits the full delay; once repeating, the shorter period applies.
    assign rpt_last = rep_q ? PerLast : DlyLast;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        rep_d     = rep_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rpt_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    state_d = StDbPress;
                    cnt_d   = CntW'(1);
                end
            end
            StDbPress: begin
                if (!s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q >= DbLast) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    rcnt_d  = '0;
                    rep_d   = 1'b0;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!s) begin
                    state_d = StDbRelease;
                    cnt_d   = CntW'(1);
                end else if (repeat_en_i) begin
                    if (rcnt_q >= rpt_last) begin
                        rpt_d  = 1'b1;
                        rcnt_d = '0;
                        rep_d  = 1'b1;
                    end else begin
                        rcnt_d = (rcnt_q == RcntMax) ? rcnt_q : rcnt_q + 1'b1;
                    end
                end else begin
                    rcnt_d = '0;
                    rep_d  = 1'b0;
                end
            end
            StDbRelease: begin
                if (s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q >= DbLast) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= {2{KEY_ACTIVE_LOW}};
            state_q   <= StIdle;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            rep_q     <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign rpt_o     = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front-end: N_KEYS independent debounce/auto-repeat channels on one clock.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS         = 3,
    parameter int unsigned DEBOUNCE_CYC   = 1000000,
    parameter int unsigned REPEAT_DLY_CYC = 50000000,
    parameter int unsigned REPEAT_PER_CYC = 10000000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] key_i,
    input  logic [N_KEYS-1:0] repeat_en_i,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] rpt_o
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
            .REPEAT_PER_CYC(REPEAT_PER_CYC),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_ch (
            .clk100_i   (clk100_i),
            .rst_i      (rst_i),
            .key_i      (key_i[i]),
            .repeat_en_i(repeat_en_i[i]),
            .level_o    (level_o[i]),
            .press_o    (press_o[i]),
            .release_o  (release_o[i]),
            .rpt_o      (rpt_o[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: vector table plus hand-written reset sequences.
module tb_key_conditioner;

    logic       clk100_i = 1'b0;
    logic       rst_i    = 1'b0;
    logic [2:0] key_i    = 3'b000;
    logic [2:0] repeat_en_i = 3'b000;
    logic [2:0] level_o, press_o, release_o, rpt_o;

    int n_checks = 0;
    int n_fail   = 0;

    key_conditioner #(
        .N_KEYS        (3),
        .DEBOUNCE_CYC  (4),
        .REPEAT_DLY_CYC(10),
        .REPEAT_PER_CYC(5),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk100_i   (clk100_i),
        .rst_i      (rst_i),
        .key_i      (key_i),
        .repeat_en_i(repeat_en_i),
        .level_o    (level_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .rpt_o      (rpt_o)
    );

    always #10 clk100_i = ~clk100_i;

    // Drive key/ren, let n rising edges pass, then compare at the next falling edge.
    typedef struct {
        logic [2:0] key;
        logic [2:0] ren;
        int         n;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] rpt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [2:0] lvl, input logic [2:0] prs,
                         input logic [2:0] rel, input logic [2:0] rpt);
        n_checks++;
        if ({level_o, press_o, release_o, rpt_o} !== {lvl, prs, rel, rpt}) begin
            n_fail++;
            $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b rpt=%b, expected lvl=%b prs=%b rel=%b rpt=%b",
                     name, $time, level_o, press_o, release_o, rpt_o, lvl, prs, rel, rpt);
        end
    endtask

    task automatic add(input logic [2:0] key, input logic [2:0] ren, input int n,
                       input logic [2:0] lvl, input logic [2:0] prs, input logic [2:0] rel,
                       input logic [2:0] rpt);
        vec_t v;
        v.key = key; v.ren = ren; v.n = n;
        v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
        tbl.push_back(v);
    endtask

    initial begin
        // Keys low (pressed) out of reset: press on the 6th edge after release.
        add(3'b000, 3'b000, 5,  3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1,  3'b111, 3'b111, 3'b000, 3'b000);
        add(3'b000, 3'b000, 1,  3'b111, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 5,  3'b111, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b111, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b000, 3'b000);
        // Key1 clean press, 20-cycle hold, release.
        add(3'b101, 3'b000, 5,  3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b101, 3'b000, 1,  3'b010, 3'b010, 3'b000, 3'b000);
        add(3'b101, 3'b000, 14, 3'b010, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 5,  3'b010, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b010, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b000, 3'b000);
        // Key0 bounce every 2 cycles for 12 cycles, then settles low.
        for (int i = 0; i < 3; i++) begin
            add(3'b110, 3'b000, 2, 3'b000, 3'b000, 3'b000, 3'b000);
            add(3'b111, 3'b000, 2, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        add(3'b110, 3'b000, 5,  3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b110, 3'b000, 1,  3'b001, 3'b001, 3'b000, 3'b000);
        add(3'b110, 3'b000, 1,  3'b001, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 5,  3'b001, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b001, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b000, 3'b000);
        // Key2 3-cycle glitch: nothing may happen.
        add(3'b011, 3'b000, 3,  3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++)
            add(3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 3,  3'b000, 3'b000, 3'b000, 3'b000);
        // Key2 auto-repeat: rpt at t0+10, +15, +20, +25; none at t0+30 once released.
        add(3'b011, 3'b100, 5,  3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b011, 3'b100, 1,  3'b100, 3'b100, 3'b000, 3'b000);
        add(3'b011, 3'b100, 9,  3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b011, 3'b100, 1,  3'b100, 3'b000, 3'b000, 3'b100);
        for (int i = 0; i < 3; i++) begin
            add(3'b011, 3'b100, 4, 3'b100, 3'b000, 3'b000, 3'b000);
            add(3'b011, 3'b100, 1, 3'b100, 3'b000, 3'b000, 3'b100);
        end
        add(3'b111, 3'b100, 5,  3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b100, 1,  3'b000, 3'b000, 3'b100, 3'b000);
        add(3'b111, 3'b100, 1,  3'b000, 3'b000, 3'b000, 3'b000);
        // Same hold with repeat disabled.
        add(3'b011, 3'b000, 5,  3'b000, 3'b000, 3'b000, 3'b000);
        add(3'b011, 3'b000, 1,  3'b100, 3'b100, 3'b000, 3'b000);
        add(3'b011, 3'b000, 10, 3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b011, 3'b000, 5,  3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 5,  3'b100, 3'b000, 3'b000, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b100, 3'b000);
        add(3'b111, 3'b000, 1,  3'b000, 3'b000, 3'b000, 3'b000);

        #1 rst_i = 1'b1;
        key_i = 3'b000;
        repeat (2) @(negedge clk100_i);
        check("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        rst_i = 1'b0;

        foreach (tbl[i]) begin
            key_i       = tbl[i].key;
            repeat_en_i = tbl[i].ren;
            repeat (tbl[i].n) @(posedge clk100_i);
            @(negedge clk100_i);
            check($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt);
        end

        // Reset while key1 is held: outputs drop at once, no release, fresh press afterwards.
        key_i       = 3'b101;
        repeat_en_i = 3'b000;
        repeat (5) @(posedge clk100_i);
        @(negedge clk100_i);
        check("rst_seq_wait", 3'b000, 3'b000, 3'b000, 3'b000);
        @(negedge clk100_i);
        check("rst_seq_press", 3'b010, 3'b010, 3'b000, 3'b000);
        repeat (3) @(negedge clk100_i);
        check("rst_seq_held", 3'b010, 3'b000, 3'b000, 3'b000);
        #2 rst_i = 1'b1;
        #1 check("rst_async", 3'b000, 3'b000, 3'b000, 3'b000);
        repeat (2) @(negedge clk100_i);
        check("rst_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk100_i);
            check($sformatf("post_rst_%0d", i), 3'b000, 3'b000, 3'b000, 3'b000);
        end
        @(negedge clk100_i);
        check("post_rst_press", 3'b010, 3'b010, 3'b000, 3'b000);
        @(negedge clk100_i);
        check("post_rst_after", 3'b010, 3'b000, 3'b000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end for the lab push-buttons. Takes raw, bouncing, active-low key_i levels and produces clean per-key strobes (press, release, auto-repeat) plus a debounced level.
- Sits between the board pins and the lab datapaths (counter and similar). Downstream logic sees exactly one single-cycle strobe per physical press.
- N_KEYS identical channels run independently, all on one clock.

Parameters:
N_KEYS, 3, number of key channels
DEBOUNCE_CYC, 1000000, consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); minimum 1
REPEAT_DLY_CYC, 50000000, cycles from press_o to first rpt_o while held
REPEAT_PER_CYC, 10000000, cycles between subsequent rpt_o pulses
KEY_ACTIVE_LOW, 1, 1 = key_i low means pressed; 0 = high means pressed

Ports:
clk100_i  in  1  system clock, 100 MHz
rst_i  in  1  asynchronous active-high reset
key_i  in  N_KEYS  raw key levels, asynchronous to clk100_i
repeat_en_i  in  N_KEYS  per-key auto-repeat enable
level_o  out  N_KEYS  debounced level, 1 = pressed
press_o  out  N_KEYS  1-cycle strobe on accepted press
release_o  out  N_KEYS  1-cycle strobe on accepted release
rpt_o  out  N_KEYS  1-cycle auto-repeat strobe

Behaviour:
- Clocking and reset: one clock, clk100_i. Reset is asynchronous, active-high, on rst_i. All flops clear immediately on rst_i.
- Reset values:
  - All outputs are 0.
  - Synchronizer flops reset to the released level: 1 if KEY_ACTIVE_LOW, else 0.
  - Every channel FSM resets to IDLE and every counter to 0.
- Synchronizer: 2-FF per key. The normalized signal s = synced key XOR KEY_ACTIVE_LOW, so s = 1 means pressed.
- Per-channel FSM:
  - IDLE (level 0):
    - s=1 -> DB_PRESS, cnt=1.
  - DB_PRESS:
    - s=0 -> IDLE, cnt=0. No output.
    - s=1 and cnt==DEBOUNCE_CYC-1 -> HELD. press_o=1 for one cycle, level_o<=1, rcnt=0.
    - Otherwise cnt++.
  - HELD (level 1):
    - s=0 -> DB_RELEASE, cnt=1.
    - Otherwise, if repeat_en_i: rcnt++. rpt_o pulses when rcnt reaches REPEAT_DLY_CYC. After that, rcnt reloads so that further pulses occur every REPEAT_PER_CYC cycles.
    - If repeat_en_i=0: rcnt holds at 0. Re-enabling restarts the REPEAT_DLY_CYC wait.
  - DB_RELEASE:
    - s=1 -> HELD, cnt=0. rcnt is kept; no repeat fires while in DB_RELEASE.
    - s=0 and cnt==DEBOUNCE_CYC-1 -> IDLE. release_o=1 for one cycle, level_o<=0.
    - Otherwise cnt++.
- Latency: if key_i changes level and stays stable, let edge E be the first edge that samples the new level. The strobe and level_o update are registered at edge E+1+DEBOUNCE_CYC.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYC synchronized samples produces no strobe and no level change.
- Exclusivity: press_o, release_o and rpt_o are never high together on the same channel. If rpt_o would coincide with leaving HELD, rpt_o is suppressed.
- Independence: channels share nothing. Simultaneous presses on several keys produce strobes in the same cycle.
- Reset mid-operation: outputs drop at once and no release_o is generated. A key still held after reset deasserts is treated as a new press, giving press_o after the normal latency.
- Counter widths: cnt is $clog2(DEBOUNCE_CYC+1) bits. rcnt is $clog2(max(REPEAT_DLY_CYC,REPEAT_PER_CYC)+1) bits. Counters saturate and never wrap.

Decomposition:
- key_pkg holds the FSM state encoding (IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_RELEASE=2'd3) and the width helper function.
- Sub-module key_debounce_ch holds one channel: synchronizer, FSM, both counters and three strobe outputs.
- key_conditioner is a generate loop over N_KEYS instances of key_debounce_ch.

Test Plan:
Bench: 20 ns clock, DEBOUNCE_CYC=4, REPEAT_DLY_CYC=10, REPEAT_PER_CYC=5, KEY_ACTIVE_LOW=1.
1. Hold rst_i=1 with key_i=3'b000 -> all outputs 0. Release reset, keys stay low -> press_o=3'b111 for one cycle, 6 edges later; level_o=3'b111.
2. Key1 1->0, hold 20 cycles, then back to 1 -> single press_o[1] 6 edges after the fall; single release_o[1] 6 edges after the rise; level_o[1] high in between.
3. Key0 bounces (toggles every 2 cycles for 12 cycles), then stays 0 -> no strobe during the bounce; exactly one press_o[0] 6 edges after the final settle.
4. Key2 low for 3 cycles only -> no press_o, release_o or level_o change.
5. repeat_en_i[2]=1, key2 held 40 cycles -> press_o[2] at t0; rpt_o[2] at t0+10, t0+15, t0+20, t0+25, ... Repeat with repeat_en_i=0 -> no rpt_o.
6. Assert rst_i while key1 is in HELD -> level_o[1]=0 immediately and no release_o. Deassert with key1 still low -> press_o[1] after 6 edges.
